// File: rtl/regwrite_tracer.sv
// Passive tracer on the regfile write port: captures non-r0 writes into a FWFT FIFO drained over valid/ready.
// Optional macro REGWRITE_TRACER_STAMP_EN adds a free-running 16-bit cycle stamp per entry (out_stamp).
module regwrite_tracer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [31:0]       data_writeReg,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_reg,
    output logic [31:0]       out_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef REGWRITE_TRACER_STAMP_EN
    output logic [15:0]       out_stamp,
`endif
    output logic [7:0]        drop_count
);

`ifdef REGWRITE_TRACER_STAMP_EN
    localparam int ENTRY_W = 53;
`else
    localparam int ENTRY_W = 37;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  rd_ptr_reg;
    logic [ADDR_W:0]    count_reg;
    logic               overflow_reg;
    logic [7:0]         drop_count_reg;

    logic               cap;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

`ifdef REGWRITE_TRACER_STAMP_EN
    logic [15:0] stamp_cnt_reg;

    // Free-running; only reset clears it, a flush does not
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stamp_cnt_reg <= '0;
        end else begin
            stamp_cnt_reg <= stamp_cnt_reg + 16'd1;
        end
    end

    assign wr_entry = {stamp_cnt_reg, ctrl_writeReg, data_writeReg};
`else
    assign wr_entry = {ctrl_writeReg, data_writeReg};
`endif

    always_comb begin
        cap   = sample_en & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
        empty = (count_reg == '0);
        full  = (count_reg == (ADDR_W+1)'(DEPTH));
        pop   = ~empty & out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        push  = cap & (~full | pop);
        drop  = cap & full & ~pop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 8'hFF) begin
                    drop_count_reg <= drop_count_reg + 8'd1;
                end
            end
        end
    end

    // Storage carries no reset; contents are masked by count when empty
    always_ff @(posedge clock) begin
        if (push & ~clear) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_comb begin
        head      = mem[rd_ptr_reg];
        out_valid = ~empty;
        out_reg   = empty ? 5'd0  : head[36:32];
        out_data  = empty ? 32'd0 : head[31:0];
`ifdef REGWRITE_TRACER_STAMP_EN
        out_stamp = empty ? 16'd0 : head[52:37];
`endif
    end

    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_regwrite_tracer.sv
// Bench for regwrite_tracer: queue-based reference model checked every cycle, directed pins, random traffic.
// Build with REGWRITE_TRACER_STAMP_EN defined to also exercise out_stamp.
module tb_regwrite_tracer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock;
    logic              reset;
    logic              sample_en;
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [31:0]       data_writeReg;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_reg;
    logic [31:0]       out_data;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        drop_count;
`ifdef REGWRITE_TRACER_STAMP_EN
    logic [15:0]       out_stamp;
`endif

    regwrite_tracer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .sample_en        (sample_en),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .clear            (clear),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_reg          (out_reg),
        .out_data         (out_data),
        .count            (count),
        .overflow         (overflow),
`ifdef REGWRITE_TRACER_STAMP_EN
        .out_stamp        (out_stamp),
`endif
        .drop_count       (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of captured writes plus drop bookkeeping
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [15:0] s;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_drops;
    int   m_cyc;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            m_cyc   = 0;
        end else begin
            bit   c;
            bit   p;
            bit   f;
            ent_t e;
            c = sample_en && ctrl_writeEnable && (ctrl_writeReg != 0);
            if (clear) begin
                q.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
            end else begin
                f = (q.size() == DEPTH);
                p = (q.size() != 0) && out_ready;
                if (p) void'(q.pop_front());
                if (c) begin
                    if (!f || p) begin
                        e.r = ctrl_writeReg;
                        e.d = data_writeReg;
                        e.s = 16'(m_cyc);
                        q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
            m_cyc = (m_cyc + 1) % 65536;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (!reset) begin
            check("valid", 32'(out_valid), 32'(q.size() != 0));
            check("count", 32'(count), 32'(q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("out_reg", 32'(out_reg), (q.size() != 0) ? 32'(q[0].r) : 32'd0);
            check("out_data", out_data, (q.size() != 0) ? q[0].d : 32'd0);
`ifdef REGWRITE_TRACER_STAMP_EN
            check("out_stamp", 32'(out_stamp), (q.size() != 0) ? 32'(q[0].s) : 32'd0);
`endif
        end
    end

    // Apply inputs for one rising edge, return at the following falling edge
    task automatic step(input logic se, input logic we, input logic [4:0] r,
                        input logic [31:0] d, input logic rdy, input logic clr);
        sample_en        = se;
        ctrl_writeEnable = we;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        out_ready        = rdy;
        clear            = clr;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 0; ctrl_writeEnable = 0; ctrl_writeReg = 0;
        data_writeReg = 0; out_ready = 0; clear = 0;
        @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_reg", 32'(out_reg), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single write, held until accepted
        step(1, 1, 5, 32'hDEADBEEF, 0, 0);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_reg", 32'(out_reg), 32'd5);
        check("single_data", out_data, 32'hDEADBEEF);
        check("single_count", 32'(count), 32'd1);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("hold_reg", 32'(out_reg), 32'd5);
        check("hold_data", out_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 1, 0);
        check("popped_count", 32'(count), 32'd0);

        // Filtering: r0 and unqualified writes
        step(1, 1, 0, 32'h1234, 0, 0);
        check("r0_count", 32'(count), 32'd0);
        step(0, 1, 7, 32'h5678, 0, 0);
        check("nose_count", 32'(count), 32'd0);
        check("nose_valid", 32'(out_valid), 32'd0);

        // Overflow: 20 captures into 16 slots
        for (int i = 1; i <= 20; i++) step(1, 1, 5'(i), 32'(i), 0, 0);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd4);
        for (int i = 1; i <= 16; i++) begin
            check("drain_reg", 32'(out_reg), 32'(i));
            check("drain_data", out_data, 32'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        check("drained_count", 32'(count), 32'd0);

        // Clear with a coincident capture
        step(1, 1, 9, 32'h99, 0, 1);
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_drops", 32'(drop_count), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("clr_nocap", 32'(out_valid), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) step(1, 1, 5'(i), 32'h100 + 32'(i), 0, 0);
        step(1, 1, 30, 32'hAA, 1, 0);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_drops", 32'(drop_count), 32'd0);
        for (int i = 2; i <= 17; i++) begin
            check("wrap_reg", 32'(out_reg), (i == 17) ? 32'd30 : 32'(i));
            check("wrap_data", out_data, (i == 17) ? 32'hAA : 32'h100 + 32'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        check("wrap_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) step(1, 1, 5'(i), 32'(i), 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

`ifdef REGWRITE_TRACER_STAMP_EN
        do_reset();
        repeat (10) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h33, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 32'h44, 0, 0);
        check("stamp_first", 32'(out_stamp), 32'd10);
        step(0, 0, 0, 0, 1, 0);
        check("stamp_second", 32'(out_stamp), 32'd13);
        step(0, 0, 0, 0, 1, 0);
`endif

        // Randomized traffic with varying consumer pressure
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            int rdy_pct;
            rdy_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
            for (int n = 0; n < 1000; n++) begin
                step(1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 4) != 0),
                     5'($urandom_range(0, 31)),
                     $urandom,
                     1'($urandom_range(0, 99) < rdy_pct),
                     1'($urandom_range(0, 199) == 0));
            end
        end
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
